montgomery_modexp_ctrl: RTL

//   Initiator for the CIOS Montgomery multiplier start/done interface: computes result = base^exp mod m.

---
 rtl/montgomery_modexp_ctrl_pkg.sv | 23 ++
 rtl/montgomery_modexp_ctrl_if.sv | 23 ++
 rtl/montgomery_modexp_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/montgomery_modexp_ctrl_pkg.sv
// Shared Montgomery types: default operand geometry and the modexp sequencer state encoding.
package montgomery_pkg;

  localparam int unsigned W_DEFAULT = 32;
  localparam int unsigned S_DEFAULT = 8;

  typedef logic [W_DEFAULT-1:0] word_t;

  // State encoding is a plain vector so legacy tooling can read the codes directly.
  typedef logic [3:0] modexp_state_t;

  localparam modexp_state_t ST_IDLE      = 4'd0;
  localparam modexp_state_t ST_TM_ISSUE  = 4'd1;
  localparam modexp_state_t ST_TM_WAIT   = 4'd2;
  localparam modexp_state_t ST_SQ_ISSUE  = 4'd3;
  localparam modexp_state_t ST_SQ_WAIT   = 4'd4;
  localparam modexp_state_t ST_MUL_ISSUE = 4'd5;
  localparam modexp_state_t ST_MUL_WAIT  = 4'd6;
  localparam modexp_state_t ST_FM_ISSUE  = 4'd7;
  localparam modexp_state_t ST_FM_WAIT   = 4'd8;
  localparam modexp_state_t ST_DONE      = 4'd9;

endpackage

// File: rtl/montgomery_modexp_ctrl_if.sv
// Start/done handshake between the modexp sequencer and one shared CIOS multiplier.
interface montgomery_modexp_ctrl_if #(
  parameter int unsigned W = 32,
  parameter int unsigned S = 8
);
  logic             mm_start;
  logic [W*S-1:0]   mm_a;
  logic [W*S-1:0]   mm_b;
  logic [W*S-1:0]   mm_m;
  logic [W-1:0]     mm_m_prime;
  logic [W*S-1:0]   mm_result;
  logic             mm_done;

  modport master (
    output mm_start, mm_a, mm_b, mm_m, mm_m_prime,
    input  mm_result, mm_done
  );

  modport slave (
    input  mm_start, mm_a, mm_b, mm_m, mm_m_prime,
    output mm_result, mm_done
  );
endinterface

// File: rtl/montgomery_modexp_ctrl.sv
// Square-and-multiply sequencer (MSB first) driving a shared Montgomery multiplier.
// Owns operand muxing and accumulators; all arithmetic happens in the multiplier.
module montgomery_modexp_ctrl
  import montgomery_pkg::*;
#(
  parameter int unsigned W      = W_DEFAULT,
  parameter int unsigned S      = S_DEFAULT,
  parameter int unsigned E_BITS = W * S
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [W*S-1:0]       base,
  input  logic [E_BITS-1:0]    exp,
  input  logic [W*S-1:0]       m,
  input  logic [W-1:0]         m_prime,
  input  logic [W*S-1:0]       r_mod,
  input  logic [W*S-1:0]       r2_mod,
  output logic [W*S-1:0]       result,
  output logic                 busy,
  output logic                 done,
  montgomery_modexp_ctrl_if.master mm
);

  localparam int unsigned N     = W * S;
  localparam int unsigned IDX_W = (E_BITS > 1) ? $clog2(E_BITS) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(E_BITS - 1);
  localparam logic [N-1:0]     MONT_ONE = N'(1);

  modexp_state_t     state_q, state_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic [N-1:0]      acc_q, acc_d;
  logic [N-1:0]      bm_q, bm_d;
  logic [N-1:0]      base_q, base_d;
  logic [E_BITS-1:0] exp_q, exp_d;
  logic [N-1:0]      r2_q, r2_d;
  logic [N-1:0]      result_q, result_d;
  logic [N-1:0]      mm_a_q, mm_a_d;
  logic [N-1:0]      mm_b_q, mm_b_d;
  logic [N-1:0]      mm_m_q, mm_m_d;
  logic [W-1:0]      mm_m_prime_q, mm_m_prime_d;
  logic              mm_start_q, mm_start_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Where to go once the current exponent bit is finished.
  logic              last_bit;
  modexp_state_t     advance_state;
  logic [IDX_W-1:0]  advance_idx;

  assign last_bit      = (bit_idx_q == '0);
  assign advance_state = last_bit ? ST_FM_ISSUE : ST_SQ_ISSUE;
  assign advance_idx   = last_bit ? bit_idx_q : bit_idx_q - IDX_W'(1);

  always_comb begin
    // NOTE: every *_d starts as its hold value so no path through the case infers a latch.
    state_d      = state_q;
    bit_idx_d    = bit_idx_q;
    acc_d        = acc_q;
    bm_d         = bm_q;
    base_d       = base_q;
    exp_d        = exp_q;
    r2_d         = r2_q;
    result_d     = result_q;
    mm_a_d       = mm_a_q;
    mm_b_d       = mm_b_q;
    mm_m_d       = mm_m_q;
    mm_m_prime_d = mm_m_prime_q;
    mm_start_d   = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d       = base;
          exp_d        = exp;
          r2_d         = r2_mod;
          mm_m_d       = m;
          mm_m_prime_d = m_prime;
          acc_d        = r_mod;
          bit_idx_d    = IDX_MAX;
          busy_d       = 1'b1;
          state_d      = ST_TM_ISSUE;
        end
      end
      // Operands only move in ISSUE states, so they stay put for the whole multiply.
      ST_TM_ISSUE: begin
        mm_a_d     = base_q;
        mm_b_d     = r2_q;
        mm_start_d = 1'b1;
        state_d    = ST_TM_WAIT;
      end
      ST_TM_WAIT: begin
        if (mm.mm_done) begin
          bm_d    = mm.mm_result;
          state_d = ST_SQ_ISSUE;
        end
      end
      ST_SQ_ISSUE: begin
        mm_a_d     = acc_q;
        mm_b_d     = acc_q;
        mm_start_d = 1'b1;
        state_d    = ST_SQ_WAIT;
      end
      ST_SQ_WAIT: begin
        if (mm.mm_done) begin
          acc_d = mm.mm_result;
          if (exp_q[bit_idx_q]) begin
            state_d = ST_MUL_ISSUE;
          end else begin
            state_d   = advance_state;
            bit_idx_d = advance_idx;
          end
        end
      end
      ST_MUL_ISSUE: begin
        mm_a_d     = acc_q;
        mm_b_d     = bm_q;
        mm_start_d = 1'b1;
        state_d    = ST_MUL_WAIT;
      end
      ST_MUL_WAIT: begin
        if (mm.mm_done) begin
          acc_d     = mm.mm_result;
          state_d   = advance_state;
          bit_idx_d = advance_idx;
        end
      end
      ST_FM_ISSUE: begin
        mm_a_d     = acc_q;
        mm_b_d     = MONT_ONE;
        mm_start_d = 1'b1;
        state_d    = ST_FM_WAIT;
      end
      ST_FM_WAIT: begin
        if (mm.mm_done) begin
          result_d = mm.mm_result;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: datapath registers are reset too, so result and multiplier operands read as zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      bit_idx_q    <= '0;
      acc_q        <= '0;
      bm_q         <= '0;
      base_q       <= '0;
      exp_q        <= '0;
      r2_q         <= '0;
      result_q     <= '0;
      mm_a_q       <= '0;
      mm_b_q       <= '0;
      mm_m_q       <= '0;
      mm_m_prime_q <= '0;
      mm_start_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of its neighbours.
      state_q      <= state_d;
      bit_idx_q    <= bit_idx_d;
      acc_q        <= acc_d;
      bm_q         <= bm_d;
      base_q       <= base_d;
      exp_q        <= exp_d;
      r2_q         <= r2_d;
      result_q     <= result_d;
      mm_a_q       <= mm_a_d;
      mm_b_q       <= mm_b_d;
      mm_m_q       <= mm_m_d;
      mm_m_prime_q <= mm_m_prime_d;
      mm_start_q   <= mm_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign result        = result_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign mm.mm_start   = mm_start_q;
  assign mm.mm_a       = mm_a_q;
  assign mm.mm_b       = mm_b_q;
  assign mm.mm_m       = mm_m_q;
  assign mm.mm_m_prime = mm_m_prime_q;

endmodule
